// File: rtl/execute_stage.sv
// execute_stage: execute stage of the fetch/decode/execute pipeline.
//
// Takes the 176-bit ID_EX bundle from decode, evaluates the ALU (or the iterative multiplier),
// resolves BEQ branches and registers a 74-bit EX_MEM bundle for the memory stage.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   id_ex_valid    in   ID_EX holds an instruction
//   ID_EX          in   decoded instruction bundle (176 bits)
//   id_ex_ready    out  stage accepts ID_EX this cycle
//   ex_mem_ready   in   memory stage accepts EX_MEM
//   ex_mem_valid   out  EX_MEM holds a result
//   EX_MEM         out  {alu_result, store_data, dest, regWrite, memRead, memWrite, memToReg, zero}
//   branch_taken   out  one-cycle pulse when a BEQ is taken
//   branch_target  out  pc + 4 + (imm << 2), meaningful while branch_taken is high
//
// Build option:
//   EXEC_FAST_MUL_EN  when defined, MUL is a single-cycle combinational op and the FSM is reduced
//                     to IDLE; otherwise a 32-iteration shift-add multiplier is used.

module execute_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         id_ex_valid,
  input  logic [175:0] ID_EX,
  output logic         id_ex_ready,
  input  logic         ex_mem_ready,
  output logic         ex_mem_valid,
  output logic [73:0]  EX_MEM,
  output logic         branch_taken,
  output logic [31:0]  branch_target
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNor  = 4'd5;
  localparam logic [3:0] OpSlt  = 4'd6;
  localparam logic [3:0] OpSltu = 4'd7;
  localparam logic [3:0] OpSll  = 4'd8;
  localparam logic [3:0] OpSrl  = 4'd9;
  localparam logic [3:0] OpSra  = 4'd10;
  localparam logic [3:0] OpLui  = 4'd11;
  localparam logic [3:0] OpMul  = 4'd12;

  // ---------------------------------------------------------------------------
  // ID_EX field extraction
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pc, rs_val, rt_val, imm;
  logic [4:0]       rt, rd;
  logic             reg_write, mem_read, mem_write, mem_to_reg;
  logic             alu_src, reg_dst, branch;
  logic [3:0]       alu_op;

  assign pc         = ID_EX[175:144];
  assign rs_val     = ID_EX[143:112];
  assign rt_val     = ID_EX[111:80];
  assign imm        = ID_EX[79:48];
  assign rt         = ID_EX[30:26];
  assign rd         = ID_EX[25:21];
  assign reg_write  = ID_EX[20];
  assign mem_read   = ID_EX[19];
  assign mem_write  = ID_EX[18];
  assign mem_to_reg = ID_EX[17];
  assign alu_src    = ID_EX[16];
  assign reg_dst    = ID_EX[15];
  assign branch     = ID_EX[14];
  assign alu_op     = ID_EX[13:10];

  // opcode, funct, rs and the reserved bits are already folded into the decoded controls
  logic unused_id_ex;
  assign unused_id_ex = ^{ID_EX[47:31], ID_EX[9:0]};

  // ---------------------------------------------------------------------------
  // Operands, ALU and branch resolution
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] op_a, op_b, alu_res, br_target_calc;
  logic [4:0]       shamt, dest;
  logic [40:0]      beat_tail;  // {store_data, dest, regWrite, memRead, memWrite, memToReg}
  logic             br_hit;

  assign op_a           = rs_val;
  assign op_b           = alu_src ? imm : rt_val;
  assign shamt          = op_b[4:0];
  assign dest           = reg_dst ? rd : rt;
  assign beat_tail      = {rt_val, dest, reg_write, mem_read, mem_write, mem_to_reg};
  // BEQ compares against rt_val even when B is the immediate
  assign br_hit         = branch && (op_a == rt_val);
  assign br_target_calc = pc + WIDTH'(4) + (imm << 2);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpXor:   alu_res = op_a ^ op_b;
      OpNor:   alu_res = ~(op_a | op_b);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      OpSll:   alu_res = op_a << shamt;
      OpSrl:   alu_res = op_a >> shamt;
      OpSra:   alu_res = $unsigned($signed(op_a) >>> shamt);
      OpLui:   alu_res = op_b << 16;
`ifdef EXEC_FAST_MUL_EN
      OpMul:   alu_res = op_a * op_b;
`endif
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  logic [73:0]      ex_mem_q, ex_mem_d;
  logic             valid_q, valid_d;
  logic             br_taken_q, br_taken_d;
  logic [WIDTH-1:0] br_target_q, br_target_d;
  logic             in_idle, accept, start_mul;

`ifndef EXEC_FAST_MUL_EN
  typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mul_mcand_q, mul_mcand_d;
  logic [WIDTH-1:0] mul_mplier_q, mul_mplier_d;
  logic [WIDTH-1:0] mul_acc_q, mul_acc_d;
  logic [5:0]       mul_cnt_q, mul_cnt_d;
  logic [40:0]      mul_tail_q, mul_tail_d;

  assign in_idle   = (state_q == StIdle);
  assign start_mul = (alu_op == OpMul);
`else
  assign in_idle   = 1'b1;
  assign start_mul = 1'b0;
`endif

  assign id_ex_ready = in_idle && (!valid_q || ex_mem_ready);
  assign accept      = id_ex_valid && id_ex_ready;

  always_comb begin
    ex_mem_d    = ex_mem_q;
    valid_d     = valid_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
`ifndef EXEC_FAST_MUL_EN
    state_d      = state_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_acc_d    = mul_acc_q;
    mul_cnt_d    = mul_cnt_q;
    mul_tail_d   = mul_tail_q;
`endif

    // A consumed beat drops valid unless something below loads a new one
    if (ex_mem_ready) valid_d = 1'b0;

    if (accept) begin
      br_taken_d = br_hit;
      if (br_hit) br_target_d = br_target_calc;
      if (start_mul) begin
`ifndef EXEC_FAST_MUL_EN
        mul_mcand_d  = op_a;
        mul_mplier_d = op_b;
        mul_acc_d    = '0;
        mul_cnt_d    = '0;
        mul_tail_d   = beat_tail;
        state_d      = StMul;
`endif
      end else begin
        ex_mem_d = {alu_res, beat_tail, alu_res == '0};
        valid_d  = 1'b1;
      end
    end

`ifndef EXEC_FAST_MUL_EN
    case (state_q)
      StMul: begin
        if (mul_cnt_q == 6'(WIDTH)) begin
          ex_mem_d = {mul_acc_q, mul_tail_q, mul_acc_q == '0};
          valid_d  = 1'b1;
          state_d  = StHold;
        end else begin
          // One multiplier bit per cycle, LSB first
          if (mul_mplier_q[0]) mul_acc_d = mul_acc_q + mul_mcand_q;
          mul_mcand_d  = mul_mcand_q << 1;
          mul_mplier_d = mul_mplier_q >> 1;
          mul_cnt_d    = mul_cnt_q + 6'd1;
        end
      end
      StHold: begin
        if (ex_mem_ready) state_d = StIdle;
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_mem_q     <= '0;
      valid_q      <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
`ifndef EXEC_FAST_MUL_EN
      state_q      <= StIdle;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_acc_q    <= '0;
      mul_cnt_q    <= '0;
      mul_tail_q   <= '0;
`endif
    end else begin
      ex_mem_q     <= ex_mem_d;
      valid_q      <= valid_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
`ifndef EXEC_FAST_MUL_EN
      state_q      <= state_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      mul_acc_q    <= mul_acc_d;
      mul_cnt_q    <= mul_cnt_d;
      mul_tail_q   <= mul_tail_d;
`endif
    end
  end

  assign EX_MEM        = ex_mem_q;
  assign ex_mem_valid  = valid_q;
  assign branch_taken  = br_taken_q;
  assign branch_target = br_target_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the driver pushes expected EX_MEM beats and branch targets
// computed by a behavioural model; a monitor pops and compares as beats are consumed.

module tb_execute_stage;

`ifdef EXEC_FAST_MUL_EN
  localparam int MulEdges = 0;
`else
  localparam int MulEdges = 33;
`endif

  logic         clock;
  logic         reset;
  logic         id_ex_valid;
  logic [175:0] ID_EX;
  logic         id_ex_ready;
  logic         ex_mem_ready;
  logic         ex_mem_valid;
  logic [73:0]  EX_MEM;
  logic         branch_taken;
  logic [31:0]  branch_target;

  execute_stage dut (
    .clock         (clock),
    .reset         (reset),
    .id_ex_valid   (id_ex_valid),
    .ID_EX         (ID_EX),
    .id_ex_ready   (id_ex_ready),
    .ex_mem_ready  (ex_mem_ready),
    .ex_mem_valid  (ex_mem_valid),
    .EX_MEM        (EX_MEM),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic rand_bp = 1'b0;

  logic [73:0] sb_q[$];
  logic [31:0] br_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc, rs_val, rt_val, imm;
    logic [4:0]  rs, rt, rd;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch;
    logic [3:0]  alu_op;
  } instr_t;

  task automatic cmp(input string name, input logic [73:0] got, input logic [73:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference ALU straight from the opcode table
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: begin
        ext = {{32{a[31]}}, a} >> sh;
        return ext[31:0];
      end
      4'd11: return {b[15:0], 16'h0000};
      4'd12: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic instr_t blank();
    instr_t t;
    t.pc = 0; t.rs_val = 0; t.rt_val = 0; t.imm = 0;
    t.rs = 0; t.rt = 0; t.rd = 0;
    t.reg_write = 0; t.mem_read = 0; t.mem_write = 0; t.mem_to_reg = 0;
    t.alu_src = 0; t.reg_dst = 0; t.branch = 0; t.alu_op = 0;
    return t;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    logic [31:0] r;
    r = $urandom;
    t.pc         = $urandom & 32'hFFFF_FFFC;
    t.rs_val     = pick();
    t.rt_val     = ($urandom_range(0, 3) == 0) ? t.rs_val : pick();
    t.imm        = ($urandom_range(0, 1) == 1) ? {{16{r[15]}}, r[15:0]} : pick();
    t.rs         = 5'($urandom);
    t.rt         = 5'($urandom);
    t.rd         = 5'($urandom);
    t.reg_write  = 1'($urandom);
    t.mem_read   = 1'($urandom);
    t.mem_write  = 1'($urandom);
    t.mem_to_reg = 1'($urandom);
    t.alu_src    = 1'($urandom);
    t.reg_dst    = 1'($urandom);
    t.branch     = ($urandom_range(0, 3) == 0);
    t.alu_op     = 4'($urandom_range(0, 15));
    return t;
  endfunction

  // Present an instruction, wait for acceptance, record expectations; returns 1 ns after the
  // accepting edge with id_ex_valid still high.
  task automatic issue(input instr_t t);
    logic [175:0] bundle;
    logic [31:0]  b, res;
    logic [73:0]  exp;
    int n;
    bundle = {t.pc, t.rs_val, t.rt_val, t.imm, 6'($urandom), 6'($urandom), t.rs, t.rt, t.rd,
              t.reg_write, t.mem_read, t.mem_write, t.mem_to_reg, t.alu_src, t.reg_dst,
              t.branch, t.alu_op, 10'($urandom)};
    b   = t.alu_src ? t.imm : t.rt_val;
    res = ref_alu(t.alu_op, t.rs_val, b);
    exp = {res, t.rt_val, (t.reg_dst ? t.rd : t.rt), t.reg_write, t.mem_read, t.mem_write,
           t.mem_to_reg, (res == 32'd0)};
    if (rand_bp) ex_mem_ready = ($urandom_range(0, 3) != 0);
    id_ex_valid = 1'b1;
    ID_EX       = bundle;
    n = 0;
    @(negedge clock);
    while (!id_ex_ready && n < 200) begin
      @(posedge clock);
      #1;
      if (rand_bp) ex_mem_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      n++;
    end
    if (!id_ex_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got id_ex_ready=0 for %0d cycles expected acceptance", n);
      id_ex_valid = 1'b0;
    end else begin
      sb_q.push_back(exp);
      if (t.branch && (t.rs_val == t.rt_val)) br_q.push_back(t.pc + 32'd4 + (t.imm << 2));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    id_ex_valid  = 1'b0;
    ex_mem_ready = 1'b1;
    while ((sb_q.size() != 0 || ex_mem_valid) && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    cmp("drain_pending", 74'(sb_q.size()), 74'd0);
  endtask

  // Monitor: compares consumed beats, hold stability and branch pulses
  logic [73:0] snap;
  logic        stall_seen = 1'b0;
  initial begin
    forever begin
      @(negedge clock or negedge reset);
      if (!reset) begin
        stall_seen = 1'b0;
        continue;
      end
      if (stall_seen) begin
        cmp("hold_stable", EX_MEM, snap);
        cmp("hold_valid", 74'(ex_mem_valid), 74'd1);
      end
      if (ex_mem_valid && ex_mem_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat", EX_MEM);
        end else begin
          cmp("ex_mem", EX_MEM, sb_q.pop_front());
        end
      end
      stall_seen = ex_mem_valid && !ex_mem_ready;
      snap       = EX_MEM;
      if (branch_taken) begin
        if (br_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_branch: got target %h expected no pulse", branch_target);
        end else begin
          cmp("branch_target", 74'(branch_target), 74'(br_q.pop_front()));
        end
      end
    end
  end

  initial begin
    instr_t t;
    int c0, lat, rises;
    logic leak;

    id_ex_valid  = 1'b0;
    ID_EX        = '0;
    ex_mem_ready = 1'b0;
    reset        = 1'b1;
    #1 reset = 1'b0;
    #2;
    cmp("rst_ex_mem", EX_MEM, 74'd0);
    cmp("rst_valid", 74'(ex_mem_valid), 74'd0);
    cmp("rst_branch", 74'(branch_taken), 74'd0);
    cmp("rst_target", 74'(branch_target), 74'd0);
    reset = 1'b1;
    #1;
    cmp("rst_ready", 74'(id_ex_ready), 74'd1);

    // Reset mid-stream at 15 ns while a beat is held
    t = blank();
    t.rs_val = 32'd1; t.rt_val = 32'd2;
    ID_EX       = {t.pc, t.rs_val, t.rt_val, 112'd0};
    id_ex_valid = 1'b1;
    @(posedge clock);
    #1;
    id_ex_valid = 1'b0;
    cmp("pre_reset_valid", 74'(ex_mem_valid), 74'd1);
    #4 reset = 1'b0;
    #1;
    cmp("midreset_ex_mem", EX_MEM, 74'd0);
    cmp("midreset_valid", 74'(ex_mem_valid), 74'd0);
    cmp("midreset_branch", 74'({branch_taken, branch_target}), 74'd0);
    sb_q.delete();
    br_q.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    cmp("post_reset_ready", 74'(id_ex_ready), 74'd1);
    @(posedge clock);
    #1;

    // ADD back-to-back, one beat per clock
    ex_mem_ready = 1'b1;
    t = blank();
    t.rs_val = 32'd5; t.rt_val = 32'd7; t.reg_dst = 1'b1; t.rd = 5'd3; t.rt = 5'd9;
    c0 = cyc;
    for (int i = 0; i < 4; i++) issue(t);
    cmp("add_throughput", 74'(cyc - c0), 74'd4);
    cmp("add_result", 74'(EX_MEM[73:42]), 74'd12);
    cmp("add_dest_zero", 74'({EX_MEM[9:5], EX_MEM[0]}), 74'({5'd3, 1'b0}));
    drain();

    // SLT / SRA / LUI
    t = blank();
    t.alu_src = 1'b1;
    t.rs_val = 32'hFFFF_FFFF; t.imm = 32'd1; t.alu_op = 4'd6;
    issue(t);
    cmp("slt", 74'(EX_MEM[73:42]), 74'h1);
    t.rs_val = 32'h8000_0000; t.imm = 32'd4; t.alu_op = 4'd10;
    issue(t);
    cmp("sra", 74'(EX_MEM[73:42]), 74'hF800_0000);
    t.rs_val = 32'hDEAD_BEEF; t.imm = 32'h1234; t.alu_op = 4'd11;
    issue(t);
    cmp("lui", 74'(EX_MEM[73:42]), 74'h1234_0000);
    drain();

    // BEQ taken
    t = blank();
    t.pc = 32'h100; t.imm = 32'hFFFF_FFFE; t.rs_val = 32'd9; t.rt_val = 32'd9;
    t.branch = 1'b1; t.alu_op = 4'd1;
    issue(t);
    id_ex_valid = 1'b0;
    cmp("beq_pulse", 74'(branch_taken), 74'd1);
    cmp("beq_target", 74'(branch_target), 74'h0000_00FC);
    cmp("beq_zero", 74'(EX_MEM[0]), 74'd1);
    @(posedge clock);
    #1;
    cmp("beq_pulse_end", 74'(branch_taken), 74'd0);
    drain();

    // MUL with backpressure
    t = blank();
    t.rs_val = 32'h10001; t.rt_val = 32'h10001; t.alu_op = 4'd12;
    issue(t);
    id_ex_valid  = 1'b0;
    ex_mem_ready = 1'b0;
    leak = 1'b0;
    lat  = 0;
    while (!ex_mem_valid && lat < 60) begin
      if (id_ex_ready) leak = 1'b1;
      @(posedge clock);
      #1;
      lat++;
    end
    cmp("mul_latency", 74'(lat), 74'(MulEdges));
    cmp("mul_result", 74'(EX_MEM[73:42]), 74'h0002_0001);
    for (int i = 0; i < 5; i++) begin
      if (id_ex_ready) leak = 1'b1;
      @(posedge clock);
      #1;
    end
    cmp("mul_ready_low", 74'(leak), 74'd0);
    ex_mem_ready = 1'b1;
    @(posedge clock);
    #1;
    cmp("mul_consumed", 74'({ex_mem_valid, id_ex_ready}), 74'b01);
    drain();

    // Reset during MUL cycle 10 aborts it
    t = rand_instr();
    t.alu_op = 4'd12; t.branch = 1'b0;
    issue(t);
    id_ex_valid = 1'b0;
    repeat (9) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    cmp("abort_valid", 74'(ex_mem_valid), 74'd0);
    sb_q.delete();
    br_q.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (ex_mem_valid) rises++;
    end
    cmp("abort_no_beat", 74'(rises), 74'd0);
    t = blank();
    t.rs_val = 32'd20; t.rt_val = 32'd22;
    issue(t);
    cmp("abort_next_add", 74'(EX_MEM[73:42]), 74'd42);
    drain();

    // Randomized traffic with backpressure and idle gaps carrying junk
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue(rand_instr());
      if ($urandom_range(0, 3) == 0) begin
        id_ex_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          ID_EX = {$urandom, $urandom, $urandom, $urandom, $urandom, 16'($urandom)};
          ex_mem_ready = ($urandom_range(0, 3) != 0);
          @(posedge clock);
          #1;
        end
      end
    end
    rand_bp = 1'b0;
    drain();
    repeat (2) @(posedge clock);
    #1;
    cmp("branch_pending", 74'(br_q.size()), 74'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
